transpose_ctrl: RTL and testbench
=================================

// Module: transpose_ctrl
// PURPOSE
//   Sequencer for the 2x64-word ping-pong transpose memory (8x8 blocks, 12-bit words).
//   Generates write and read addresses and the write enable, tracks bank occupancy,
//   and adds valid/ready handshakes on both sides.
//   The producer writes a block row-major into one bank while the consumer reads the
//   other bank column-major.
//   Sits between the row-pass and column-pass stages of the 2-D transform.
// PARAMETERS
//   (none) localparam BLK_WORDS = 64, words per bank. Fixed by the memory geometry.
// PORTS
//   clk        in   1  clock; all logic on posedge
//   reset      in   1  synchronous, active-high
//   in_valid   in   1  producer has a word on the memory data-in bus this cycle
//   in_ready   out  1  controller accepts a word this cycle
//   in_last    out  1  accepted word is word 63 of its block
//   wren       out  1  memory write enable
//   waddr      out  7  memory write address: {wbank, wcnt[5:0]}
//   raddr      out  7  memory read address: {rbank, index}
//   out_valid  out  1  memory data-out bus holds a valid word
//   out_ready  in   1  consumer accepts the data-out word
//   out_first  out  1  valid word is word 0 of a block
//   out_last   out  1  valid word is word 63 of a block
//   full       out  2  bank occupancy flags; bit b = bank b holds a complete unread block
// BEHAVIOUR
//   Reset
//     - full=0, wbank=0, wcnt=0, rbank=0, rcnt=0, read FSM=R_IDLE.
//     - out_valid=0, out_first=0, out_last=0, in_last=0.
//     - Reset mid-block discards all partial and complete blocks. No memory clear.
//   Write side (combinational outputs)
//     - in_ready = ~full[wbank]; wren = in_valid & in_ready.
//     - waddr = {wbank, wcnt}; in_last = wren & (wcnt==63).
//     - On wren: wcnt++.
//     - At wcnt==63: wcnt wraps to 0, full[wbank] is set, wbank toggles.
//     - Counting is row-major; the memory's swapped coordinate decode performs the transpose.
//   Read FSM, registered. Issue = the cycle in which raddr is sampled by the memory.
//     - R_IDLE: if full[rbank], go to R_STREAM with rcnt=0.
//     - R_STREAM: issue when ~out_valid | out_ready.
//       - On issue: out_valid<=1, rcnt++.
//       - out_first<=(rcnt==0), out_last<=(rcnt==63).
//       - After issuing rcnt==63, go to R_DRAIN.
//     - R_DRAIN: no issue.
//       - On out_valid & out_ready & out_last: clear full[rbank], toggle rbank,
//         out_valid<=0, go to R_IDLE.
//     - Outside R_STREAM, out_valid clears when out_ready.
//   Read address and latency
//     - Memory read latency is 1 cycle: data for an address issued at edge T is valid
//       after T with out_valid=1.
//     - raddr = {rbank, rcnt} when issuing.
//     - When stalled (out_valid & ~out_ready), raddr = {rbank, rcnt-1}. The memory
//       re-reads the held word, so data-out is stable under backpressure.
//   Bank release
//     - A bank is freed only when its word 63 is consumed, never merely on issue.
//       This prevents the writer overwriting a word still held under a stall.
//   Simultaneous events
//     - Setting full[wbank] and clearing full[rbank] in the same cycle is legal;
//       they are always different banks.
//   Throughput
//     - Sustained 1 word/cycle per side.
//     - Read side inserts 2 bubble cycles between blocks (R_DRAIN -> R_IDLE -> R_STREAM).
//   Both banks full: in_ready=0 until the read side frees a bank.
//   Both banks empty: out_valid=0 and the read FSM stays in R_IDLE.
// TESTING
//   1. Write 64 words 0..63 with in_valid=1, out_ready=1.
//      -> full=01 after word 63.
//      -> Reads words 0,8,16,..,56,1,9,.. in order.
//      -> out_first on word 0, out_last on word 63.
//   2. Write 3 blocks back-to-back with out_ready=0.
//      -> in_ready drops after 128 words, full=11.
//      -> Raising out_ready drains bank 0, then bank 1.
//      -> Third block is accepted once bank 0 is freed.
//   3. Toggle out_ready randomly (50%).
//      -> Data-out is stable while out_valid & ~out_ready.
//      -> No word is lost or duplicated; the transposed sequence matches the model.
//   4. Stall out_ready=0 on word 63 for 100 cycles while the producer streams.
//      -> Writer fills only the other bank.
//      -> Held word 63 is unchanged until accepted.
//   5. Assert reset at write word 30 and read word 40.
//      -> All outputs return to reset values next cycle.
//      -> Next block writes to bank 0 from waddr=0.
//   6. Continuous streaming of 10 blocks.
//      -> Input side: 1 word/cycle.
//      -> Output side: 64 valid words per 66 cycles.
//      -> waddr[6] and raddr[6] alternate per block.

Source files
------------

// File: rtl/transpose_ctrl.sv
// Address/handshake sequencer for a 2x64-word ping-pong transpose memory.
// The producer fills one bank row-major while the consumer streams the other bank out.
module transpose_ctrl (
  input  logic       clk,
  input  logic       reset,
  input  logic       in_valid,
  output logic       in_ready,
  output logic       in_last,
  output logic       wren,
  output logic [6:0] waddr,
  output logic [6:0] raddr,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       out_first,
  output logic       out_last,
  output logic [1:0] full
);

  localparam int         BLK_WORDS = 64;
  localparam logic [5:0] LAST_IDX  = 6'(BLK_WORDS - 1);

  localparam logic [1:0] R_IDLE   = 2'd0;
  localparam logic [1:0] R_STREAM = 2'd1;
  localparam logic [1:0] R_DRAIN  = 2'd2;

  logic [1:0] full_r;
  logic       wbank_r;
  logic [5:0] wcnt_r;
  logic       rbank_r;
  logic [5:0] rcnt_r;
  logic [1:0] state_r;
  logic       out_valid_r;
  logic       out_first_r;
  logic       out_last_r;

  logic       wren_s;
  logic       wr_done_s;
  logic       issue_s;
  logic       stall_s;
  logic       rd_done_s;
  logic [1:0] set_mask_s;
  logic [1:0] clr_mask_s;
  logic [1:0] full_nxt_s;
  logic [5:0] rd_idx_s;

  // Handshake qualifiers, bank-occupancy update and the read index presented to the memory
  always_comb begin
    wren_s     = in_valid & ~full_r[wbank_r];
    wr_done_s  = wren_s & (wcnt_r == LAST_IDX);
    issue_s    = (state_r == R_STREAM) & (~out_valid_r | out_ready);
    stall_s    = out_valid_r & ~out_ready;
    rd_done_s  = (state_r == R_DRAIN) & out_valid_r & out_ready & out_last_r;
    set_mask_s = wr_done_s ? (wbank_r ? 2'b10 : 2'b01) : 2'b00;
    clr_mask_s = rd_done_s ? (rbank_r ? 2'b10 : 2'b01) : 2'b00;
    full_nxt_s = (full_r | set_mask_s) & ~clr_mask_s;
    // A stalled word is re-read from its own address so data-out holds steady
    rd_idx_s   = stall_s ? (rcnt_r - 6'd1) : rcnt_r;
  end

  assign in_ready  = ~full_r[wbank_r];
  assign wren      = wren_s;
  assign in_last   = wr_done_s;
  assign waddr     = {wbank_r, wcnt_r};
  assign raddr     = {rbank_r, rd_idx_s};
  assign out_valid = out_valid_r;
  assign out_first = out_first_r;
  assign out_last  = out_last_r;
  assign full      = full_r;

  // Write-side counter, bank pointer and occupancy flags
  always_ff @(posedge clk) begin
    if (reset) begin
      full_r  <= 2'b00;
      wbank_r <= 1'b0;
      wcnt_r  <= 6'd0;
    end else begin
      full_r <= full_nxt_s;
      if (wren_s) begin
        wcnt_r <= wcnt_r + 6'd1;
        if (wr_done_s) begin
          wbank_r <= ~wbank_r;
        end else begin
          wbank_r <= wbank_r;
        end
      end else begin
        wcnt_r  <= wcnt_r;
        wbank_r <= wbank_r;
      end
    end
  end

  // Read sequencer: a bank is released only once its final word has been consumed
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= R_IDLE;
      rbank_r <= 1'b0;
      rcnt_r  <= 6'd0;
    end else begin
      case (state_r)
        R_IDLE: begin
          rcnt_r <= 6'd0;
          if (full_r[rbank_r]) begin
            state_r <= R_STREAM;
          end else begin
            state_r <= R_IDLE;
          end
        end
        R_STREAM: begin
          if (issue_s) begin
            rcnt_r <= rcnt_r + 6'd1;
            if (rcnt_r == LAST_IDX) begin
              state_r <= R_DRAIN;
            end else begin
              state_r <= R_STREAM;
            end
          end else begin
            rcnt_r <= rcnt_r;
          end
        end
        R_DRAIN: begin
          if (rd_done_s) begin
            rbank_r <= ~rbank_r;
            state_r <= R_IDLE;
          end else begin
            state_r <= R_DRAIN;
          end
        end
        default: begin
          state_r <= R_IDLE;
          rcnt_r  <= 6'd0;
        end
      endcase
    end
  end

  // Output-word qualifiers track the address issued one cycle earlier
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_r <= 1'b0;
      out_first_r <= 1'b0;
      out_last_r  <= 1'b0;
    end else if (issue_s) begin
      out_valid_r <= 1'b1;
      out_first_r <= (rcnt_r == 6'd0);
      out_last_r  <= (rcnt_r == LAST_IDX);
    end else if (out_ready) begin
      out_valid_r <= 1'b0;
      out_first_r <= 1'b0;
      out_last_r  <= 1'b0;
    end else begin
      out_valid_r <= out_valid_r;
      out_first_r <= out_first_r;
      out_last_r  <= out_last_r;
    end
  end

endmodule

// File: tb/tb_transpose_ctrl.sv
// Randomised scoreboard bench for transpose_ctrl with a 1-cycle-latency transpose memory model.
module tb_transpose_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic        in_last;
  logic        wren;
  logic [6:0]  waddr;
  logic [6:0]  raddr;
  logic        out_valid;
  logic        out_ready;
  logic        out_first;
  logic        out_last;
  logic [1:0]  full;
  logic [11:0] din;
  logic [11:0] dout;
  logic [11:0] mem [0:127];

  always #5 clk = ~clk;

  transpose_ctrl dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_last(in_last),
    .wren(wren), .waddr(waddr), .raddr(raddr), .out_valid(out_valid), .out_ready(out_ready),
    .out_first(out_first), .out_last(out_last), .full(full)
  );

  // Memory stores each word at its swapped (column,row) position; reads take one cycle
  always @(posedge clk) begin
    if (wren) mem[{waddr[6], waddr[2:0], waddr[5:3]}] <= din;
    dout <= mem[raddr];
  end

  typedef struct { logic [11:0] d; logic f; logic l; } exp_t;
  exp_t exp_q[$];

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
    end
  endtask

  // Scoreboard / monitor state
  int          cyc = 0;
  logic [11:0] blk_buf [64];
  int          wr_idx = 0;
  bit          wr_par = 1'b0;
  int          rd_idx = 0;
  bit          rd_par = 1'b0;
  int          wr_total = 0;
  int          blk_out = 0;
  bit          hold_v = 1'b0;
  logic [11:0] held_d;
  int          first_cycs[$];
  int          last_cycs[$];
  int          wr_cycs[$];

  always @(negedge clk) begin
    exp_t e;
    cyc++;
    if (reset) begin
      exp_q.delete();
      wr_idx = 0; wr_par = 1'b0; rd_idx = 0; rd_par = 1'b0; hold_v = 1'b0;
    end else begin
      if (hold_v && out_valid) chk("hold_stable", dout, held_d);
      if (out_valid && !out_ready) chk("stall_raddr", raddr, {rd_par, 6'(rd_idx)});
      if (wren) begin
        chk("waddr", waddr, {wr_par, 6'(wr_idx)});
        chk("in_last", in_last, (wr_idx == 63));
        blk_buf[wr_idx] = din;
        wr_total++;
        wr_cycs.push_back(cyc);
        if (wr_idx == 63) begin
          for (int j = 0; j < 64; j++) begin
            e.d = blk_buf[(j % 8) * 8 + j / 8];
            e.f = (j == 0);
            e.l = (j == 63);
            exp_q.push_back(e);
          end
          wr_idx = 0;
          wr_par = ~wr_par;
        end else begin
          wr_idx++;
        end
      end
      if (out_valid && out_ready) begin
        chk("raddr_bank", raddr[6], rd_par);
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_output actual=%0h required=none", dout);
        end else begin
          e = exp_q.pop_front();
          chk("out_data", dout, e.d);
          chk("out_first", out_first, e.f);
          chk("out_last", out_last, e.l);
        end
        if (out_first) first_cycs.push_back(cyc);
        if (out_last) last_cycs.push_back(cyc);
        if (rd_idx == 63) begin
          rd_idx = 0;
          rd_par = ~rd_par;
          blk_out++;
        end else begin
          rd_idx++;
        end
      end
      hold_v = out_valid && !out_ready;
      held_d = dout;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [11:0] d, input int gap);
    int t;
    in_valid = 1'b0;
    repeat (gap) tick();
    in_valid = 1'b1;
    din = d;
    t = 0;
    @(negedge clk);
    while (!in_ready && t < 3000) begin
      t++;
      @(negedge clk);
    end
    if (!in_ready) begin
      checks++;
      failures++;
      $display("FAIL send_timeout actual=in_ready_low required=accept");
    end
    tick();
    in_valid = 1'b0;
  endtask

  task automatic produce(input int n, input int maxgap, input bit seq);
    for (int i = 0; i < n; i++) begin
      send(seq ? 12'(i) : 12'($urandom_range(0, 4095)), (maxgap > 0) ? $urandom_range(0, maxgap) : 0);
    end
  endtask

  task automatic wait_blocks(input int target);
    int t;
    t = 0;
    while (blk_out < target && t < 5000) begin
      tick();
      t++;
    end
    chk("drain_blocks", blk_out, target);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=running required=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1);
  end

  initial begin
    int b0;
    int t;
    reset = 1'b1; in_valid = 1'b0; din = 12'd0; out_ready = 1'b0;
    repeat (2) tick();
    @(negedge clk);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_first", out_first, 1'b0);
    chk("rst_out_last", out_last, 1'b0);
    chk("rst_in_last", in_last, 1'b0);
    chk("rst_full", full, 2'b00);
    chk("rst_waddr", waddr, 7'd0);
    chk("rst_in_ready", in_ready, 1'b1);
    tick();
    reset = 1'b0;

    // Single ordered block, free-flowing consumer
    out_ready = 1'b1;
    produce(64, 0, 1'b1);
    @(negedge clk);
    chk("t1_full", full, 2'b01);
    wait_blocks(1);

    // Three blocks against a blocked consumer
    out_ready = 1'b0;
    b0 = wr_total;
    fork
      produce(192, 0, 1'b0);
      begin : t2_ctl
        int t2;
        t2 = 0;
        while (wr_total < b0 + 128 && t2 < 3000) begin
          @(negedge clk);
          t2++;
        end
        repeat (3) @(negedge clk);
        chk("t2_full", full, 2'b11);
        chk("t2_in_ready", in_ready, 1'b0);
        tick();
        out_ready = 1'b1;
      end
    join
    wait_blocks(4);

    // Random producer gaps and random consumer backpressure
    b0 = blk_out;
    fork
      produce(256, 3, 1'b0);
      begin : t3_ctl
        int t3;
        t3 = 0;
        while (blk_out < b0 + 4 && t3 < 20000) begin
          out_ready = 1'($urandom_range(0, 1));
          tick();
          t3++;
        end
        out_ready = 1'b1;
      end
    join
    wait_blocks(b0 + 4);

    // Long stall on the final word of a block while the producer keeps streaming
    b0 = blk_out;
    out_ready = 1'b1;
    fork
      produce(192, 0, 1'b0);
      begin : t4_ctl
        int t4;
        t4 = 0;
        while (!(out_valid && out_last) && t4 < 3000) begin
          tick();
          t4++;
        end
        out_ready = 1'b0;
        repeat (100) tick();
        @(negedge clk);
        chk("t4_out_valid", out_valid, 1'b1);
        chk("t4_out_last", out_last, 1'b1);
        chk("t4_full", full, 2'b11);
        chk("t4_in_ready", in_ready, 1'b0);
        tick();
        out_ready = 1'b1;
      end
    join
    wait_blocks(b0 + 3);

    // Reset in the middle of both a write and a read block
    out_ready = 1'b1;
    produce(94, 0, 1'b0);
    t = 0;
    while (rd_idx < 40 && t < 3000) begin
      tick();
      t++;
    end
    reset = 1'b1;
    in_valid = 1'b1;
    din = 12'habc;
    tick();
    @(negedge clk);
    chk("t5_out_valid", out_valid, 1'b0);
    chk("t5_out_first", out_first, 1'b0);
    chk("t5_out_last", out_last, 1'b0);
    chk("t5_full", full, 2'b00);
    chk("t5_in_last", in_last, 1'b0);
    chk("t5_waddr", waddr, 7'd0);
    chk("t5_in_ready", in_ready, 1'b1);
    tick();
    reset = 1'b0;
    in_valid = 1'b0;
    b0 = blk_out;
    produce(64, 0, 1'b0);
    wait_blocks(b0 + 1);

    // Ten blocks of continuous streaming
    repeat (3) tick();
    first_cycs.delete();
    last_cycs.delete();
    wr_cycs.delete();
    b0 = blk_out;
    out_ready = 1'b1;
    produce(640, 0, 1'b0);
    wait_blocks(b0 + 10);
    chk("t6_blocks", last_cycs.size(), 10);
    if (wr_cycs.size() >= 128) chk("t6_in_rate", wr_cycs[127] - wr_cycs[0], 127);
    if (last_cycs.size() >= 10 && first_cycs.size() >= 1)
      chk("t6_out_rate", last_cycs[9] - first_cycs[0], 657);
    chk("t6_exp_empty", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
